// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding the DAC serializer: valid/ready push, one pop per LRCK falling edge.
// Build option AUDIO_FIFO_MUTE_ON_UNDERRUN_EN: output silence on underrun instead of repeating the last pair.
module audio_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic [DATA_WIDTH-1:0] iL_DATA,
  input  logic [DATA_WIDTH-1:0] iR_DATA,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iLRCK,
  input  logic                  iClr_Underrun,
  output logic [DATA_WIDTH-1:0] oL_SAMPLE,
  output logic [DATA_WIDTH-1:0] oR_SAMPLE,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic [7:0]            oUnderrun_Cnt,
  output logic                  oUnderrun
);

  localparam int unsigned              DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]      ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]    ONE_PTR    = DEPTH_LOG2'(1);

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    lrck_d;

  logic frame_tick;
  logic push;
  logic pop;
  logic underrun;

  assign oReady     = (count != FULL_COUNT);
  assign oLevel     = count;
  assign frame_tick = lrck_d && !iLRCK;
  assign push       = iValid && oReady;
  // Pop and underrun both look at the pre-push count, so a push landing on
  // an empty frame edge is stored for the next frame rather than bypassed.
  assign pop        = frame_tick && (count != '0);
  assign underrun   = frame_tick && (count == '0);

  // NOTE: the sample array carries no reset; stale entries are unreachable
  // because count gates every read, and leaving it unreset lets it map to RAM.
  always_ff @(posedge iCLK_18_4) begin
    if (push) begin
      mem[wr_ptr] <= {iL_DATA, iR_DATA};
    end
  end

  // NOTE: every state register uses non-blocking assignment so all blocks
  // see the same pre-edge values regardless of evaluation order.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lrck_d <= 1'b0;
    end else begin
      lrck_d <= iLRCK;
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      if (push && !pop) begin
        count <= count + ONE_COUNT;
      end else if (pop && !push) begin
        count <= count - ONE_COUNT;
      end
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oL_SAMPLE <= '0;
      oR_SAMPLE <= '0;
    end else if (pop) begin
      {oL_SAMPLE, oR_SAMPLE} <= mem[rd_ptr];
    end else if (underrun) begin
`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
      oL_SAMPLE <= '0;
      oR_SAMPLE <= '0;
`else
      oL_SAMPLE <= oL_SAMPLE;
      oR_SAMPLE <= oR_SAMPLE;
`endif
    end
  end

  // Clear has priority over a same-cycle increment; the pulse is unaffected.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oUnderrun_Cnt <= 8'd0;
      oUnderrun     <= 1'b0;
    end else begin
      oUnderrun <= underrun;
      if (iClr_Underrun) begin
        oUnderrun_Cnt <= 8'd0;
      end else if (underrun && (oUnderrun_Cnt != 8'hFF)) begin
        oUnderrun_Cnt <= oUnderrun_Cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomized and directed bench for audio_sample_fifo against a queue-based frame model.
// Honours AUDIO_FIFO_MUTE_ON_UNDERRUN_EN for the expected underrun output values.
module tb_audio_sample_fifo;

  localparam int DW    = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic            iCLK_18_4 = 1'b0;
  logic            iRST_N    = 1'b0;
  logic [DW-1:0]   iL_DATA   = '0;
  logic [DW-1:0]   iR_DATA   = '0;
  logic            iValid    = 1'b0;
  logic            oReady;
  logic            iLRCK     = 1'b0;
  logic            iClr_Underrun = 1'b0;
  logic [DW-1:0]   oL_SAMPLE;
  logic [DW-1:0]   oR_SAMPLE;
  logic [DL2:0]    oLevel;
  logic [7:0]      oUnderrun_Cnt;
  logic            oUnderrun;

  audio_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .iCLK_18_4    (iCLK_18_4),
    .iRST_N       (iRST_N),
    .iL_DATA      (iL_DATA),
    .iR_DATA      (iR_DATA),
    .iValid       (iValid),
    .oReady       (oReady),
    .iLRCK        (iLRCK),
    .iClr_Underrun(iClr_Underrun),
    .oL_SAMPLE    (oL_SAMPLE),
    .oR_SAMPLE    (oR_SAMPLE),
    .oLevel       (oLevel),
    .oUnderrun_Cnt(oUnderrun_Cnt),
    .oUnderrun    (oUnderrun)
  );

  always #5 iCLK_18_4 = ~iCLK_18_4;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of {L,R} pairs plus the per-frame output state.
  logic [31:0] q[$];
  logic [15:0] m_l, m_r;
  int          m_cnt;
  bit          m_pulse;
  bit          m_lrck;

  task automatic m_reset();
    q.delete();
    m_l = '0; m_r = '0; m_cnt = 0; m_pulse = 0; m_lrck = 0;
  endtask

  task automatic m_edge();
    bit can_push, tick;
    can_push = (q.size() != DEPTH);
    tick     = m_lrck && !iLRCK;
    m_pulse  = 0;
    if (tick) begin
      if (q.size() > 0) begin
        {m_l, m_r} = q.pop_front();
      end else begin
        m_pulse = 1;
        if (m_cnt < 255) m_cnt++;
`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
        m_l = '0; m_r = '0;
`endif
      end
    end
    if (iClr_Underrun) m_cnt = 0;
    if (iValid && can_push) q.push_back({iL_DATA, iR_DATA});
    m_lrck = iLRCK;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ready"}, 32'(oReady), 32'(q.size() != DEPTH));
    check({tag, ".level"}, 32'(oLevel), 32'(q.size()));
    check({tag, ".l"},     32'(oL_SAMPLE), 32'(m_l));
    check({tag, ".r"},     32'(oR_SAMPLE), 32'(m_r));
    check({tag, ".ucnt"},  32'(oUnderrun_Cnt), 32'(m_cnt));
    check({tag, ".upls"},  32'(oUnderrun), 32'(m_pulse));
  endtask

  // Drive at the falling edge, let the DUT and model see one rising edge, compare at the next falling edge.
  task automatic step(input string tag, input bit v, input logic [15:0] l, input logic [15:0] r,
                      input bit lrck, input bit clr);
    iValid = v; iL_DATA = l; iR_DATA = r; iLRCK = lrck; iClr_Underrun = clr;
    @(posedge iCLK_18_4);
    m_edge();
    @(negedge iCLK_18_4);
    compare_all(tag);
  endtask

  task automatic frame(input string tag);
    step(tag, 0, '0, '0, 1, 0);
    step(tag, 0, '0, '0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    iValid = 0; iLRCK = 0; iClr_Underrun = 0;
    iRST_N = 0;
    #1;
    m_reset();
    compare_all(tag);
    @(negedge iCLK_18_4);
    iRST_N = 1;
  endtask

  initial begin
    logic [15:0] exp_l, exp_r;
    bit          lr;
    @(negedge iCLK_18_4);
    do_reset("rst0");

    // Single pair out on the first falling edge.
    step("t1.push", 1, 16'h1234, 16'hABCD, 0, 0);
    check("t1.lvl1", 32'(oLevel), 32'd1);
    frame("t1.frame");
    check("t1.l", 32'(oL_SAMPLE), 32'h1234);
    check("t1.r", 32'(oR_SAMPLE), 32'hABCD);
    check("t1.lvl0", 32'(oLevel), 32'd0);

    // Fill to full, stall a held pair, release it with one frame.
    do_reset("rst1");
    for (int i = 0; i < DEPTH; i++) step("t2.fill", 1, 16'(i), 16'(100 + i), 0, 0);
    check("t2.full_lvl", 32'(oLevel), 32'd16);
    check("t2.full_rdy", 32'(oReady), 32'd0);
    step("t2.stall", 1, 16'h5555, 16'h6666, 0, 0);
    step("t2.stall_hi", 1, 16'h5555, 16'h6666, 1, 0);
    step("t2.pop", 1, 16'h5555, 16'h6666, 0, 0);
    check("t2.pop_lvl", 32'(oLevel), 32'd15);
    check("t2.pop_rdy", 32'(oReady), 32'd1);
    step("t2.accept", 1, 16'h5555, 16'h6666, 0, 0);
    check("t2.acc_lvl", 32'(oLevel), 32'd16);

    // Pointer wrap: 40 sequential pairs streamed through 16 entries.
    do_reset("rst2");
    for (int i = 0; i < DEPTH; i++) step("t3.fill", 1, 16'(i), 16'(~i), 0, 0);
    for (int n = 0; n < 40; n++) begin
      frame("t3.frame");
      exp_l = 16'(n);
      exp_r = 16'(~n);
      check("t3.seq_l", 32'(oL_SAMPLE), 32'(exp_l));
      check("t3.seq_r", 32'(oR_SAMPLE), 32'(exp_r));
      step("t3.refill", 1, 16'(n + 16), 16'(~(n + 16)), 0, 0);
    end

    // Underrun behaviour after a known last pair.
    do_reset("rst3");
    step("t4.push", 1, 16'h7FFF, 16'h8001, 0, 0);
    frame("t4.pop");
    for (int i = 0; i < 3; i++) begin
      frame("t4.under");
      check("t4.pulse", 32'(oUnderrun), 32'd1);
    end
    check("t4.cnt", 32'(oUnderrun_Cnt), 32'd3);
`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
    check("t4.l", 32'(oL_SAMPLE), 32'h0000);
    check("t4.r", 32'(oR_SAMPLE), 32'h0000);
`else
    check("t4.l", 32'(oL_SAMPLE), 32'h7FFF);
    check("t4.r", 32'(oR_SAMPLE), 32'h8001);
`endif

    // Saturation and clear-on-underrun priority.
    for (int i = 0; i < 300; i++) frame("t5.sat");
    check("t5.sat", 32'(oUnderrun_Cnt), 32'd255);
    step("t5.hi", 0, '0, '0, 1, 0);
    step("t5.clr", 0, '0, '0, 0, 1);
    check("t5.clr_cnt", 32'(oUnderrun_Cnt), 32'd0);
    check("t5.clr_pls", 32'(oUnderrun), 32'd1);

    // Asynchronous reset with pairs stored and non-zero outputs.
    do_reset("rst4");
    for (int i = 0; i < 6; i++) step("t6.fill", 1, 16'(i + 1), 16'(i + 50), 0, 0);
    frame("t6.pop");
    check("t6.lvl5", 32'(oLevel), 32'd5);
    #2;
    iRST_N = 0;
    #1;
    m_reset();
    check("t6.async_lvl", 32'(oLevel), 32'd0);
    check("t6.async_rdy", 32'(oReady), 32'd1);
    check("t6.async_l", 32'(oL_SAMPLE), 32'd0);
    check("t6.async_r", 32'(oR_SAMPLE), 32'd0);
    @(negedge iCLK_18_4);
    iRST_N = 1;
    frame("t6.after");
    check("t6.under_pls", 32'(oUnderrun), 32'd1);
    check("t6.under_cnt", 32'(oUnderrun_Cnt), 32'd1);

    // Randomized traffic against the model.
    do_reset("rst5");
    lr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) lr = ~lr;
      step("rnd", 1'($urandom_range(1)), 16'($urandom), 16'($urandom), lr,
           $urandom_range(63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
